sc_req_arbiter: RTL and testbench



---
 rtl/sc_req_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_sc_req_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_req_arbiter.sv
// Round-robin arbiter sharing one single-outstanding transaction port among NUM_REQ requesters,
// with per-requester accept/completion pulses and a WAIT-phase completion timeout.
module sc_req_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 40,
    parameter int unsigned ID_WIDTH   = 12,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_wstrb,
    input  logic [NUM_REQ*8-1:0]             req_len,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic                             m_we,
    output logic [ADDR_WIDTH-1:0]            m_addr,
    output logic [DATA_WIDTH-1:0]            m_wdata,
    output logic [DATA_WIDTH/8-1:0]          m_wstrb,
    output logic [7:0]                       m_len,
    output logic [ID_WIDTH-1:0]              m_id,
    input  logic                             m_done,
    input  logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             busy,
    output logic [$clog2(NUM_REQ)-1:0]       grant_idx
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_W-1:0]     wstrb;
        logic [7:0]            len;
    } mreq_t;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic                  m_valid_q, m_valid_d;
    mreq_t                 mreq_q, mreq_d;
    logic [TO_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  busy_q, busy_d;

    mreq_t                 lane [NUM_REQ];
    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      rr_next;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane[gi] = '{we:    req_we[gi],
                            addr:  req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH],
                            wdata: req_wdata[gi*DATA_WIDTH +: DATA_WIDTH],
                            wstrb: req_wstrb[gi*STRB_W +: STRB_W],
                            len:   req_len[gi*8 +: 8]};
    end

    // First requesting index scanning upward from rr_q with wrap-around
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_q;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            int unsigned cand;
            cand = 32'(rr_q) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && req_valid[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign rr_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        m_valid_d   = m_valid_q;
        mreq_d      = mreq_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ack     = '0;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d   = win_idx;
                    mreq_d    = lane[win_idx];
                    m_valid_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_valid_q && m_ready) begin
                    req_ack[grant_q] = 1'b1;
                    m_valid_d        = 1'b0;
                    cnt_d            = '0;
                    state_d          = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion takes priority over a simultaneous timeout expiry
                if (m_done) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d          = m_rdata;
                    rsp_err_d            = 1'b0;
                    rr_d                 = rr_next;
                    state_d              = S_IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1))) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d          = '0;
                    rsp_err_d            = 1'b1;
                    rr_d                 = rr_next;
                    state_d              = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            m_valid_q   <= 1'b0;
            mreq_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            m_valid_q   <= m_valid_d;
            mreq_q      <= mreq_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_we      = mreq_q.we;
    assign m_addr    = mreq_q.addr;
    assign m_wdata   = mreq_q.wdata;
    assign m_wstrb   = mreq_q.wstrb;
    assign m_len     = mreq_q.len;
    assign m_id      = ID_WIDTH'(grant_q);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_sc_req_arbiter.sv
// Bench for sc_req_arbiter: table of arbitration vectors, hand-written corner sequences,
// and a completion scoreboard checked by a monitor whenever rsp_valid fires.
module tb_sc_req_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 40;
    localparam int unsigned IW = 12;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_wstrb;
    logic [N*8-1:0]    req_len;
    logic [N-1:0]      req_ack;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              m_valid;
    logic              m_ready;
    logic              m_we;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic [7:0]        m_len;
    logic [IW-1:0]     m_id;
    logic              m_done;
    logic [DW-1:0]     m_rdata;
    logic              busy;
    logic [1:0]        grant_idx;

    sc_req_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_len(req_len),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_len(m_len), .m_id(m_id),
        .m_done(m_done), .m_rdata(m_rdata), .busy(busy), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [DW-1:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [N-1:0]  pat;
        int            exp_g;
        int            ready_dly;
        int            done_dly;
        logic [DW-1:0] rd;
    } vec_t;

    rsp_t        sb[$];
    vec_t        vecs[13];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [N-1:0] we_pat = 4'b0101;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return 40'h0C00 + AW'(i) * 40'h200;
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int i);
        return 64'hA5A5_0000_0000_0000 | DW'(i + 1);
    endfunction

    function automatic logic [SW-1:0] wstrb_of(input int i);
        return SW'(8'h11 << i);
    endfunction

    function automatic logic [7:0] len_of(input int i);
        return 8'((i + 2) % 4);
    endfunction

    task automatic load_lanes();
        req_we = we_pat;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = addr_of(i);
            req_wdata[i*DW +: DW] = wdata_of(i);
            req_wstrb[i*SW +: SW] = wstrb_of(i);
            req_len[i*8 +: 8]     = len_of(i);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every rsp_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'h0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    // From an idle cycle: request, grant, optional stall, handshake; returns in the first WAIT cycle
    task automatic grant_and_issue(input logic [N-1:0] pat, input int exp_g,
                                   input int ready_dly, input bit done_in_issue);
        req_valid = pat;
        tick();
        check("grant_m_valid", 64'(m_valid), 64'h1);
        req_valid = '0;
        req_addr[exp_g*AW +: AW]  = 40'hFF_FFFF_FFFF;
        req_wdata[exp_g*DW +: DW] = '1;
        check("grant_idx", 64'(grant_idx), 64'(exp_g));
        check("grant_m_id", 64'(m_id), 64'(exp_g));
        check("grant_m_addr", 64'(m_addr), 64'(addr_of(exp_g)));
        check("grant_m_we", 64'(m_we), 64'(we_pat[exp_g]));
        check("grant_m_len", 64'(m_len), 64'(len_of(exp_g)));
        check("grant_busy", 64'(busy), 64'h1);
        for (int d = 0; d < ready_dly; d++) begin
            if (done_in_issue && d == 0) begin
                m_done  = 1'b1;
                m_rdata = 64'hBAD;
            end
            check("issue_no_ack", 64'(req_ack), 64'h0);
            tick();
            m_done = 1'b0;
            check("issue_hold_valid", 64'(m_valid), 64'h1);
            check("issue_no_rsp", 64'(rsp_valid), 64'h0);
        end
        m_ready = 1'b1;
        #1;
        check("req_ack", 64'(req_ack), 64'(1) << exp_g);
        tick();
        m_ready = 1'b0;
        #1;
        check("wait_m_valid", 64'(m_valid), 64'h0);
        check("wait_busy", 64'(busy), 64'h1);
        check("wait_m_addr_hold", 64'(m_addr), 64'(addr_of(exp_g)));
        check("wait_m_wdata_hold", m_wdata, wdata_of(exp_g));
        check("wait_m_wstrb_hold", 64'(m_wstrb), 64'(wstrb_of(exp_g)));
        load_lanes();
    endtask

    // From WAIT cycle 0: complete with m_done after wait_cycles; returns in the rsp_valid cycle
    task automatic complete(input int exp_g, input logic [DW-1:0] rd, input int wait_cycles);
        for (int k = 0; k < wait_cycles; k++) tick();
        m_done  = 1'b1;
        m_rdata = rd;
        sb.push_back('{idx: exp_g, rdata: rd, err: 1'b0});
        tick();
        m_done  = 1'b0;
        m_rdata = 64'hBAD0_BAD0;
        check("done_busy_clear", 64'(busy), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          early;
        bit          dup;
        vecs[0]  = '{4'b0100, 2, 2, 2, 64'hDEAD};
        vecs[1]  = '{4'b1111, 3, 0, 0, 64'hC0DE_0001};
        vecs[2]  = '{4'b1111, 0, 1, 0, 64'hC0DE_0002};
        vecs[3]  = '{4'b1111, 1, 0, 1, 64'hC0DE_0003};
        vecs[4]  = '{4'b1111, 2, 0, 0, 64'hC0DE_0004};
        vecs[5]  = '{4'b1111, 3, 0, 3, 64'hC0DE_0005};
        vecs[6]  = '{4'b1010, 1, 0, 0, 64'hC0DE_0006};
        vecs[7]  = '{4'b0100, 2, 0, 0, 64'hC0DE_0007};
        vecs[8]  = '{4'b1010, 3, 0, 0, 64'hC0DE_0008};
        vecs[9]  = '{4'b0011, 0, 0, 0, 64'hC0DE_0009};
        vecs[10] = '{4'b0001, 0, 1, 0, 64'hC0DE_000A};
        vecs[11] = '{4'b1100, 2, 0, 0, 64'hC0DE_000B};
        vecs[12] = '{4'b1000, 3, 0, 0, 64'hC0DE_000C};

        rst_n = 1'b0;
        req_valid = '0;
        m_ready = 1'b0;
        m_done = 1'b0;
        m_rdata = '0;
        load_lanes();
        #12;
        check("rst_m_valid", 64'(m_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_req_ack", 64'(req_ack), 64'h0);
        check("rst_grant_idx", 64'(grant_idx), 64'h0);
        check("rst_m_addr", 64'(m_addr), 64'h0);
        check("rst_m_id", 64'(m_id), 64'h0);
        check("rst_rsp_rdata", rsp_rdata, 64'h0);
        check("rst_rsp_err", 64'(rsp_err), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Arbitration table starting from rr_ptr = 0
        for (int v = 0; v < 13; v++) begin
            grant_and_issue(vecs[v].pat, vecs[v].exp_g, vecs[v].ready_dly, 1'b0);
            complete(vecs[v].exp_g, vecs[v].rd, vecs[v].done_dly);
        end

        // Timeout: no m_done, error completion exactly TO cycles after WAIT cycle 0
        grant_and_issue(4'b0010, 1, 0, 1'b0);
        m_rdata = 64'hBAD0_BAD0;
        sb.push_back('{idx: 1, rdata: '0, err: 1'b1});
        early = 1'b0;
        for (int k = 1; k <= int'(TO); k++) begin
            tick();
            if (k < int'(TO)) begin
                if (rsp_valid != '0) early = 1'b1;
            end else begin
                check("timeout_rsp_at_limit", 64'(rsp_valid), 64'h2);
            end
        end
        check("timeout_not_early", 64'(early), 64'h0);
        check("timeout_busy_clear", 64'(busy), 64'h0);

        // m_done on the last WAIT cycle beats expiry, and no duplicate response follows
        grant_and_issue(4'b0100, 2, 0, 1'b0);
        complete(2, 64'h1234, int'(TO) - 1);
        dup = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (rsp_valid != '0) dup = 1'b1;
        end
        check("race_no_duplicate", 64'(dup), 64'h0);

        // m_done during ISSUE is ignored; withdrawn request still issues and completes
        grant_and_issue(4'b1000, 3, 2, 1'b1);
        complete(3, 64'hCAFE, 1);

        // Asynchronous reset in WAIT abandons the transaction; pointer returns to 0
        grant_and_issue(4'b0010, 1, 0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("rstwait_m_valid", 64'(m_valid), 64'h0);
        check("rstwait_busy", 64'(busy), 64'h0);
        check("rstwait_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rstwait_req_ack", 64'(req_ack), 64'h0);
        #2;
        rst_n = 1'b1;
        grant_and_issue(4'b0011, 0, 0, 1'b0);
        complete(0, 64'h77, 0);

        // All requesters held continuously from reset: grants rotate 0,1,2,3,0
        tick();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req_valid = 4'b1111;
        m_ready = 1'b1;
        m_done = 1'b1;
        m_rdata = 64'h5555;
        for (int g = 0; g < 5; g++) begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
            end while (req_ack == '0 && n < 6);
            check("rr_ack", 64'(req_ack), 64'(1) << (g % 4));
            check("rr_grant_idx", 64'(grant_idx), 64'(g % 4));
            sb.push_back('{idx: g % 4, rdata: 64'h5555, err: 1'b0});
        end
        req_valid = '0;
        tick();
        tick();
        tick();
        m_ready = 1'b0;
        m_done = 1'b0;
        tick();
        check("end_idle", 64'(busy), 64'h0);
        check("sb_drained", 64'(sb.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
